// File: rtl/rdma_req_sched_pkg.sv
// Shared types and constants for the RDMA request scheduler.
package rdma_req_sched_pkg;

  localparam int N_REGIONS             = 4;
  localparam int N_REGIONS_BITS        = 2;
  localparam int RDMA_N_WR_OUTSTANDING = 32;
  localparam int RDMA_SCHED_N_CRED     = 8;
  localparam int RDMA_SCHED_CRED_BITS  = $clog2(RDMA_SCHED_N_CRED) + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [N_REGIONS_BITS-1:0] vfid;
    logic [4:0]                opcode;
    logic [47:0]               vaddr;
    logic [27:0]               len;
    logic                      last;
  } dreq_t;

endpackage

// File: rtl/rdma_req_sched_if.sv
// Valid/ready request bundle with N dreq_t lanes; N=1 for the scheduled output.
interface rdma_req_sched_if #(
  parameter int N = 1
);
  import rdma_req_sched_pkg::*;

  logic [N-1:0]  valid;
  logic [N-1:0]  ready;
  dreq_t [N-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/rdma_req_sched_rr_arbiter.sv
// Combinational round-robin arbiter: lowest request at or above ptr wins,
// otherwise the lowest request overall (mask-and-double-encode).
module rdma_req_sched_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [N-1:0]  masked_s;
  logic [PW-1:0] idx_m_s;
  logic [PW-1:0] idx_u_s;

  // Two priority encoders run high-to-low so the lowest set bit is the last writer.
  always_comb begin
    masked_s = '0;
    idx_m_s  = '0;
    idx_u_s  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      masked_s[i] = req[i] & (PW'(i) >= ptr);
      idx_m_s     = masked_s[i] ? PW'(i) : idx_m_s;
      idx_u_s     = req[i]      ? PW'(i) : idx_u_s;
    end
    idx = (|masked_s) ? idx_m_s : idx_u_s;
    gnt = '0;
    if (|req) begin
      gnt[idx] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/rdma_req_sched.sv
// Credit-capped round-robin scheduler sharing one request path among N_REQ regions.
// Optional grant statistics are built when RDMA_SCHED_STATS_EN is defined.
module rdma_req_sched
  import rdma_req_sched_pkg::*;
#(
  parameter int N_REQ  = N_REGIONS,
  parameter int N_CRED = RDMA_SCHED_N_CRED
) (
  input  logic                      aclk,
  input  logic                      areset,
  rdma_req_sched_if.slave           s_req,
  rdma_req_sched_if.master          m_req,
  input  logic                      s_cpl_valid,
  input  logic [N_REGIONS_BITS-1:0] s_cpl_vfid,
  output logic                      cred_err,
  input  logic                      stat_clr,
  output logic [N_REQ-1:0][31:0]    stat_grants
);

  localparam int CW = $clog2(N_CRED) + 1;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t               state_q;
  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0][CW-1:0] cred_q, cred_d;
  logic                     cred_err_q, cred_err_d;
  logic                     m_valid_q;
  dreq_t                    m_data_q;
  logic [N_REQ-1:0]         elig_s, gnt_s, take_s, cpl_s;
  logic [PW-1:0]            gnt_idx_s;
  logic                     grant_s;

  // A requester competes only while it still holds a credit.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig_s[i] = s_req.valid[i] & (cred_q[i] != '0);
    end
  end

  rdma_req_sched_rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req (elig_s),
    .ptr (rr_ptr_q),
    .gnt (gnt_s),
    .idx (gnt_idx_s)
  );

  assign grant_s     = (state_q == ST_IDLE) & (|elig_s) & ~areset;
  assign take_s      = grant_s ? gnt_s : '0;
  assign s_req.ready = take_s;

  // Credit bookkeeping: a grant and a completion on the same index cancel out.
  always_comb begin
    cred_d     = cred_q;
    cred_err_d = cred_err_q;
    cpl_s      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cpl_s[i] = s_cpl_valid & (s_cpl_vfid == N_REGIONS_BITS'(i));
      if (take_s[i] && !cpl_s[i]) begin
        cred_d[i] = cred_q[i] - CW'(1);
      end else if (cpl_s[i] && !take_s[i]) begin
        if (cred_q[i] == CW'(N_CRED)) begin
          cred_err_d = 1'b1;
        end else begin
          cred_d[i] = cred_q[i] + CW'(1);
        end
      end else begin
        cred_d[i] = cred_q[i];
      end
    end
    if (grant_s) begin
      rr_ptr_d = (gnt_idx_s == PW'(N_REQ - 1)) ? '0 : gnt_idx_s + PW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Two-state handoff FSM with a single registered output slot.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      rr_ptr_q   <= '0;
      cred_q     <= {N_REQ{CW'(N_CRED)}};
      cred_err_q <= 1'b0;
    end else begin
      cred_q     <= cred_d;
      cred_err_q <= cred_err_d;
      rr_ptr_q   <= rr_ptr_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_s) begin
            m_data_q  <= s_req.data[gnt_idx_s];
            m_valid_q <= 1'b1;
            state_q   <= ST_SEND;
          end else begin
            m_valid_q <= 1'b0;
          end
        end
        ST_SEND: begin
          if (m_req.ready[0]) begin
            m_valid_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            m_valid_q <= 1'b1;
          end
        end
        default: begin
          m_valid_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_req.valid   = m_valid_q;
  assign m_req.data[0] = m_data_q;
  assign cred_err      = cred_err_q;

`ifdef RDMA_SCHED_STATS_EN
  logic [N_REQ-1:0][31:0] stat_q;

  // Saturating per-requester grant counters; clear beats a same-cycle grant.
  always_ff @(posedge aclk) begin
    if (areset || stat_clr) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (take_s[i] && (stat_q[i] != 32'hFFFF_FFFF)) begin
          stat_q[i] <= stat_q[i] + 32'd1;
        end else begin
          stat_q[i] <= stat_q[i];
        end
      end
    end
  end

  assign stat_grants = stat_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_grants     = '0;
`endif

endmodule
